rca_seq: RTL and testbench

Parametrised multi-cycle ripple-carry adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock through a CHUNK-bit ripple-carry slice, carrying between chunks in a register. Operation uses a start/busy/done handshake. It is the area-lean arithmetic unit for datapaths where a full-width combinational ripple chain is too slow or too large.

---
 rtl/rca_pkg.sv | 19 +
 rtl/rca_seq_if.sv | 25 ++
 rtl/full_adder.sv | 11 +
 rtl/rca_chunk.sv | 28 ++
 rtl/rca_seq.sv | 115 +++++++++++
 tb/tb_rca_seq.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/rca_pkg.sv
// Shared types and configuration helpers for the sequential ripple-carry adder.
package rca_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of CHUNK-bit slices needed to cover WIDTH bits.
    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // A legal configuration has a non-zero chunk that divides the width exactly.
    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/rca_seq_if.sv
// Start/busy/done handshake plus operand and result bus for rca_seq.
interface rca_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, s, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, s, c_out, ovf
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; c_msb is the carry into the top bit.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (c[i]),
            .s    (s[i]),
            .c_out(c[i+1])
        );
    end

    assign c_out = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/rca_seq.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock,
// inter-chunk carry held in a register, start/busy/done handshake.
module rca_seq
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    rca_seq_if.slave  bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("rca_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state, state_next;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r, b_r, p, p_next;
    logic             carry;
    logic             accept, last;
    int               base;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_co, sl_cmsb;

    logic             done_r, c_out_r, ovf_r;
    logic [WIDTH-1:0] s_r;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: if (idx == LAST) begin
                last       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        base   = int'(idx) * CHUNK;
        sl_a   = a_r[base +: CHUNK];
        sl_b   = b_r[base +: CHUNK];
        p_next = p;
        p_next[base +: CHUNK] = sl_s;
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (sl_a),
        .b    (sl_b),
        .c_in (carry),
        .s    (sl_s),
        .c_out(sl_co),
        .c_msb(sl_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: operand, partial and carry registers are reset as well, so an aborted
    // operation leaves no trace in internal state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            p       <= '0;
            carry   <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                // Subtraction is a + ~b + 1: invert b once here and force the carry-in.
                a_r   <= bus.a;
                b_r   <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub | bus.c_in;
                idx   <= '0;
            end else if (state == RUN) begin
                p     <= p_next;
                carry <= sl_co;
                idx   <= idx + 1'b1;
                if (last) begin
                    idx     <= '0;
                    s_r     <= p_next;
                    c_out_r <= sl_co;
                    ovf_r   <= sl_cmsb ^ sl_co;
                    done_r  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = done_r;
    assign bus.s     = s_r;
    assign bus.c_out = c_out_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_rca_seq.sv
// Scoreboard bench for rca_seq (WIDTH=16, CHUNK=4): driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_rca_seq;
    localparam int W   = 16;
    localparam int LAT = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t sbq[$];
    int   done_cycles[$];
    exp_t hold;

    rca_seq_if #(.WIDTH(W)) bus ();

    rca_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference: whole-word two's-complement arithmetic with a 17-bit sum.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0]   sum;
        logic [W-1:0] bb;
        exp_t e;
        bb    = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
        e.s   = sum[W-1:0];
        e.c   = sum[W];
        e.v   = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: busy window, done results, latency and output holding.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            logic exp_busy;
            exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].acc) && (cyc < sbq[0].acc + LAT);
            check("busy", 32'(bus.busy), 32'(exp_busy));
            if (bus.done) begin
                done_cycles.push_back(cyc);
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("latency", 32'(cyc - e.acc), 32'(LAT));
                    check("s",       32'(bus.s),     32'(e.s));
                    check("c_out",   32'(bus.c_out), 32'(e.c));
                    check("ovf",     32'(bus.ovf),   32'(e.v));
                    hold = e;
                end
            end else begin
                check("hold_s",     32'(bus.s),     32'(hold.s));
                check("hold_c_out", 32'(bus.c_out), 32'(hold.c));
                check("hold_ovf",   32'(bus.ovf),   32'(hold.v));
            end
        end
    end

    // Issue one operation from a negedge; optionally keep start high with junk operands
    // through the whole RUN phase, which must be ignored.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input bit hold_start);
        exp_t e;
        int   n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("issue_timeout", 32'd1, 32'd0);
        bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub; bus.start = 1'b1;
        e     = model(a, b, cin, sub);
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        if (hold_start) begin
            for (int i = 0; i < LAT; i++) begin
                bus.a    = W'($urandom);
                bus.b    = W'($urandom);
                bus.c_in = 1'($urandom);
                bus.sub  = 1'($urandom);
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        hold = '{s: '0, c: 1'b0, v: 1'b0, acc: 0};

        // Reset with start pulses: nothing may happen.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'(i % 2 == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            check("rst_busy",  32'(bus.busy),  32'd0);
            check("rst_done",  32'(bus.done),  32'd0);
            check("rst_s",     32'(bus.s),     32'd0);
            check("rst_c_out", 32'(bus.c_out), 32'd0);
            check("rst_ovf",   32'(bus.ovf),   32'd0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases: plain add, full ripple, signed overflow, subtraction.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0); drain();
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0); drain();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0); drain();
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0); drain();
        issue(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0); drain();

        // start held through RUN is ignored; start in the done cycle is accepted.
        done_cycles.delete();
        issue(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        issue(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
        drain();
        check("b2b_count", 32'(done_cycles.size()), 32'd2);
        if (done_cycles.size() >= 2)
            check("b2b_gap", 32'(done_cycles[1] - done_cycles[0]), 32'(LAT + 1));

        // Reset during the second RUN cycle aborts without a done pulse.
        issue(16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(bus.busy),  32'd0);
        check("abort_done",  32'(bus.done),  32'd0);
        check("abort_s",     32'(bus.s),     32'd0);
        check("abort_c_out", 32'(bus.c_out), 32'd0);
        check("abort_ovf",   32'(bus.ovf),   32'd0);
        sbq.delete();
        hold = '{s: '0, c: 1'b0, v: 1'b0, acc: 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0); drain();

        // Randomized traffic with random gaps, held starts and back-to-back issues.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
